// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module : stack_pkg
// Brief  : Op codes, entry-cost helper and default sizing for the stack
//          command arbiter.
// Rev    : 1.0
// ============================================================================
package stack_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_STACK_SIZE = 3;
    localparam int DEF_LEVEL_W    = 2;

    localparam logic [1:0] OP_POP        = 2'b00;
    localparam logic [1:0] OP_PUSH_HALF  = 2'b01;
    localparam logic [1:0] OP_PUSH_WORD  = 2'b10;
    localparam logic [1:0] OP_PUSH_SPLIT = 2'b11;

    // Number of datapath entries a command adds (POP removes one instead).
    function automatic logic [1:0] op_cost(input logic [1:0] op);
        case (op)
            OP_POP:        op_cost = 2'd0;
            OP_PUSH_SPLIT: op_cost = 2'd2;
            default:       op_cost = 2'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter, one-hot grant, pointer moves to the
//          requester that lost (or was idle) after every grant.
// Rev    : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (o_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (o_gnt[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stack_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : stack_cmd_arbiter
// Brief  : Shares one stack datapath between two requesters; mirrors the
//          occupancy so only legal commands issue, and routes pop results.
// Rev    : 1.0
// ============================================================================
module stack_cmd_arbiter
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STACK_SIZE = DEF_STACK_SIZE,
    parameter int LEVEL_W    = DEF_LEVEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [1:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [1:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sm_en,
    output logic [1:0]            sm_ctl,
    output logic [DATA_WIDTH-1:0] sm_data_in,
    input  logic [DATA_WIDTH-1:0] sm_data_out,
    input  logic                  sm_wait,
    output logic [LEVEL_W-1:0]    level,
    output logic                  full,
    output logic                  empty,
    output logic                  err_overflow
);

    localparam int               CNT_W = LEVEL_W + 1;
    localparam logic [LEVEL_W-1:0] c_one = LEVEL_W'(1);

    logic [LEVEL_W-1:0]    r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_err;
    logic [1:0]            r_rsp_pend;
    logic [1:0]            w_qual;
    logic [1:0]            w_gnt;
    logic [1:0]            w_op_sel;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic [LEVEL_W-1:0]    w_level_nxt;

    // Wider sum so a split push near the top cannot wrap the comparison.
    function automatic logic cmd_legal(input logic [1:0] op, input logic [LEVEL_W-1:0] lvl);
        if (op == OP_POP) begin
            cmd_legal = (lvl != '0);
        end else begin
            cmd_legal = (({1'b0, lvl} + CNT_W'(op_cost(op))) <= CNT_W'(STACK_SIZE));
        end
    endfunction

    assign w_qual[0] = req0_valid & cmd_legal(req0_op, r_level);
    assign w_qual[1] = req1_valid & cmd_legal(req1_op, r_level);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_qual),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_op_sel   = OP_POP;
        w_data_sel = '0;
        if (w_gnt[0]) begin
            w_op_sel   = req0_op;
            w_data_sel = req0_data;
        end else if (w_gnt[1]) begin
            w_op_sel   = req1_op;
            w_data_sel = req1_data;
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        if (|w_gnt) begin
            if (w_op_sel == OP_POP) begin
                w_level_nxt = r_level - c_one;
            end else begin
                w_level_nxt = r_level + LEVEL_W'(op_cost(w_op_sel));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_rsp_pend <= 2'b00;
            r_err      <= 1'b0;
        end else begin
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LEVEL_W'(STACK_SIZE));
            r_empty    <= (w_level_nxt == '0);
            r_rsp_pend <= w_gnt & {req1_op == OP_POP, req0_op == OP_POP};
            r_err      <= r_err | sm_wait;
        end
    end

    assign req0_ready   = w_gnt[0];
    assign req1_ready   = w_gnt[1];
    assign sm_en        = |w_gnt;
    assign sm_ctl       = w_op_sel;
    assign sm_data_in   = w_data_sel;
    assign rsp0_valid   = r_rsp_pend[0];
    assign rsp1_valid   = r_rsp_pend[1];
    assign rsp_data     = (|r_rsp_pend) ? sm_data_out : '0;
    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stack_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_stack_cmd_arbiter
// Brief  : Self-checking bench with a FIFO-style datapath emulator and a
//          behavioural reference model of the arbiter.
// Rev    : 1.0
// ============================================================================
module tb_stack_cmd_arbiter;
    import stack_pkg::*;

    localparam int DW = 16;
    localparam int SS = 3;
    localparam int LW = 2;
    localparam int HW = DW / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [1:0]    req0_op, req1_op;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_data;
    logic          sm_en;
    logic [1:0]    sm_ctl;
    logic [DW-1:0] sm_data_in, sm_data_out;
    logic          sm_wait;
    logic [LW-1:0] level;
    logic          full, empty, err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stack_cmd_arbiter #(.DATA_WIDTH(DW), .STACK_SIZE(SS), .LEVEL_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .sm_en(sm_en), .sm_ctl(sm_ctl), .sm_data_in(sm_data_in),
        .sm_data_out(sm_data_out), .sm_wait(sm_wait),
        .level(level), .full(full), .empty(empty), .err_overflow(err_overflow)
    );

    // Datapath emulator: oldest-first entries, registered pop output,
    // overflow pulse on any command it cannot honour.
    logic [DW-1:0] dp_q[$];
    logic          dp_ovf;
    logic          force_wait;
    assign sm_wait = force_wait | dp_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_q.delete();
            sm_data_out <= '0;
            dp_ovf      <= 1'b0;
        end else begin
            dp_ovf <= 1'b0;
            if (sm_en) begin
                case (sm_ctl)
                    OP_POP: begin
                        if (dp_q.size() == 0) dp_ovf <= 1'b1;
                        else sm_data_out <= dp_q.pop_front();
                    end
                    OP_PUSH_HALF: dp_q.push_back({{HW{1'b0}}, sm_data_in[HW-1:0]});
                    OP_PUSH_WORD: dp_q.push_back(sm_data_in);
                    default: begin
                        dp_q.push_back({{HW{1'b0}}, sm_data_in[HW-1:0]});
                        dp_q.push_back({{HW{1'b0}}, sm_data_in[DW-1:HW]});
                    end
                endcase
                while (dp_q.size() > SS) begin
                    dp_ovf <= 1'b1;
                    void'(dp_q.pop_back());
                end
            end
        end
    end

    // Reference model state and per-cycle expectations
    int            m_level, m_pref, m_pend;
    logic [DW-1:0] m_pend_data;
    logic          m_err;
    logic [DW-1:0] m_q[$];
    logic          e_g0, e_g1;
    logic [1:0]    e_ctl;
    logic [DW-1:0] e_din;

    function automatic int cost(input logic [1:0] op);
        if (op == OP_POP) return 0;
        if (op == OP_PUSH_SPLIT) return 2;
        return 1;
    endfunction

    function automatic bit allowed(input logic [1:0] op, input int lvl);
        if (op == OP_POP) return lvl >= 1;
        return (lvl + cost(op)) <= SS;
    endfunction

    task automatic model_reset();
        m_level = 0;
        m_pref  = 0;
        m_pend  = -1;
        m_pend_data = '0;
        m_err   = 1'b0;
        m_q.delete();
    endtask

    task automatic predict();
        bit q0, q1;
        q0 = req0_valid && allowed(req0_op, m_level);
        q1 = req1_valid && allowed(req1_op, m_level);
        e_g0  = q0 && (!q1 || m_pref == 0);
        e_g1  = q1 && (!q0 || m_pref == 1);
        e_ctl = e_g0 ? req0_op : (e_g1 ? req1_op : 2'b00);
        e_din = e_g0 ? req0_data : (e_g1 ? req1_data : '0);
    endtask

    task automatic advance();
        m_pend = -1;
        if (force_wait) m_err = 1'b1;
        if (e_g0 || e_g1) begin
            m_pref = e_g0 ? 1 : 0;
            case (e_ctl)
                OP_POP: begin
                    m_pend_data = m_q.pop_front();
                    m_pend  = e_g0 ? 0 : 1;
                    m_level = m_level - 1;
                end
                OP_PUSH_HALF: m_q.push_back({{HW{1'b0}}, e_din[HW-1:0]});
                OP_PUSH_WORD: m_q.push_back(e_din);
                default: begin
                    m_q.push_back({{HW{1'b0}}, e_din[HW-1:0]});
                    m_q.push_back({{HW{1'b0}}, e_din[DW-1:HW]});
                end
            endcase
            m_level = m_level + cost(e_ctl);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0; req0_op = 2'b00; req0_data = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        force_wait = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one cycle's requests and move to the sampling point.
    task automatic step(input bit v0, input logic [1:0] o0, input logic [DW-1:0] d0,
                        input bit v1, input logic [1:0] o1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_op = o0; req0_data = d0;
        req1_valid = v1; req1_op = o1; req1_data = d1;
        predict();
        @(negedge clk);
    endtask

    task automatic next();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst = 1'b1;
        drive_idle();
        force_wait = 1'b0;
        #3;
        obs = {sm_en, rsp0_valid, rsp1_valid, req0_ready, req1_ready, full, empty, err_overflow, level == '0};
        n_checks++;
        if (obs !== 9'b000000_1_0_1) begin
            n_errors++; $display("FAIL reset_state: got %b expected %b", obs, 9'b000000101);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, OP_POP, '0, 0, OP_POP, '0);
            obs = {sm_en, rsp0_valid, rsp1_valid, req0_ready, req1_ready, full, empty, err_overflow, level == '0};
            n_checks++;
            if (obs !== 9'b000000101) begin
                n_errors++; $display("FAIL idle_state cycle %0d: got %b expected %b", i, obs, 9'b000000101);
            end
            next();
        end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] exp_d[3];
        exp_d[0] = 16'h1234; exp_d[1] = 16'h00CD; exp_d[2] = 16'h00AB;
        do_reset();
        step(1, OP_PUSH_WORD, 16'h1234, 0, OP_POP, '0);
        n_checks++;
        if ({req0_ready, sm_en, sm_ctl, sm_data_in} !== {1'b1, 1'b1, OP_PUSH_WORD, 16'h1234}) begin
            n_errors++; $display("FAIL push_word_issue: got %h expected %h",
                {req0_ready, sm_en, sm_ctl, sm_data_in}, {1'b1, 1'b1, OP_PUSH_WORD, 16'h1234});
        end
        next();
        step(1, OP_PUSH_SPLIT, 16'hABCD, 0, OP_POP, '0);
        n_checks++;
        if ({req0_ready, level} !== {1'b1, 2'd1}) begin
            n_errors++; $display("FAIL split_issue: got ready/level %b expected %b", {req0_ready, level}, 3'b101);
        end
        next();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(0, OP_POP, '0, 1, OP_POP, '0);
            else step(0, OP_POP, '0, 0, OP_POP, '0);
            if (i == 0) begin
                n_checks++;
                if ({level, full, req1_ready} !== {2'd3, 1'b1, 1'b1}) begin
                    n_errors++; $display("FAIL full_after_split: got %b expected %b", {level, full, req1_ready}, 4'b1111);
                end
            end else begin
                n_checks++;
                if ({rsp1_valid, rsp0_valid, rsp_data} !== {1'b1, 1'b0, exp_d[i-1]}) begin
                    n_errors++; $display("FAIL pop_rsp %0d: got %b/%b %h expected 1/0 %h",
                        i - 1, rsp1_valid, rsp0_valid, rsp_data, exp_d[i-1]);
                end
            end
            next();
        end
        step(0, OP_POP, '0, 0, OP_POP, '0);
        n_checks++;
        if ({rsp1_valid, rsp_data, level, empty} !== {1'b0, 16'h0000, 2'd0, 1'b1}) begin
            n_errors++; $display("FAIL after_pops: got %b %h %0d %b expected 0 0000 0 1",
                rsp1_valid, rsp_data, level, empty);
        end
        next();
    endtask

    task automatic test_alternate();
        logic [3:0] exp_r0, exp_r1;
        exp_r0 = 4'b0101; exp_r1 = 4'b0010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, OP_PUSH_HALF, 16'h0011, 1, OP_PUSH_HALF, 16'h0022);
            n_checks++;
            if ({req0_ready, req1_ready} !== {exp_r0[i], exp_r1[i]}) begin
                n_errors++; $display("FAIL alternate cycle %0d: got r0/r1 %b%b expected %b%b",
                    i, req0_ready, req1_ready, exp_r0[i], exp_r1[i]);
            end
            next();
        end
        step(1, OP_PUSH_HALF, 16'h0011, 1, OP_PUSH_HALF, 16'h0022);
        n_checks++;
        if ({full, sm_en, req0_ready, req1_ready} !== 4'b1000) begin
            n_errors++; $display("FAIL alternate_full_wait: got %b expected 1000", {full, sm_en, req0_ready, req1_ready});
        end
        next();
    endtask

    task automatic test_split_block();
        do_reset();
        step(1, OP_PUSH_HALF, 16'h0005, 0, OP_POP, '0); next();
        step(0, OP_POP, '0, 1, OP_PUSH_HALF, 16'h0006); next();
        step(1, OP_PUSH_SPLIT, 16'hBEEF, 1, OP_POP, '0);
        n_checks++;
        if ({req0_ready, req1_ready, sm_ctl, level} !== {1'b0, 1'b1, OP_POP, 2'd2}) begin
            n_errors++; $display("FAIL split_blocked: got %b expected %b",
                {req0_ready, req1_ready, sm_ctl, level}, {1'b0, 1'b1, OP_POP, 2'd2});
        end
        next();
        step(1, OP_PUSH_SPLIT, 16'hBEEF, 0, OP_POP, '0);
        n_checks++;
        if ({req0_ready, level, rsp1_valid, rsp_data} !== {1'b1, 2'd1, 1'b1, 16'h0005}) begin
            n_errors++; $display("FAIL split_unblocked: got r0=%b lvl=%0d rsp1=%b data=%h expected 1 1 1 0005",
                req0_ready, level, rsp1_valid, rsp_data);
        end
        next();
        step(0, OP_POP, '0, 0, OP_POP, '0);
        n_checks++;
        if ({level, full} !== {2'd3, 1'b1}) begin
            n_errors++; $display("FAIL split_level: got %0d/%b expected 3/1", level, full);
        end
        next();
    endtask

    task automatic test_pop_empty();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, OP_POP, '0, 0, OP_POP, '0);
            n_checks++;
            if ({req0_ready, sm_en, sm_ctl, sm_data_in} !== '0) begin
                n_errors++; $display("FAIL pop_empty_held %0d: got ready=%b en=%b ctl=%b din=%h expected all 0",
                    i, req0_ready, sm_en, sm_ctl, sm_data_in);
            end
            next();
        end
        step(1, OP_POP, '0, 1, OP_PUSH_WORD, 16'h5A5A);
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_errors++; $display("FAIL pop_empty_push: got %b%b expected 01", req0_ready, req1_ready);
        end
        next();
        step(1, OP_POP, '0, 0, OP_POP, '0);
        n_checks++;
        if ({req0_ready, sm_en, sm_ctl} !== {1'b1, 1'b1, OP_POP}) begin
            n_errors++; $display("FAIL pop_unblocked: got %b expected 1100", {req0_ready, sm_en, sm_ctl});
        end
        next();
        step(0, OP_POP, '0, 0, OP_POP, '0);
        n_checks++;
        if ({rsp0_valid, rsp1_valid, rsp_data} !== {1'b1, 1'b0, 16'h5A5A}) begin
            n_errors++; $display("FAIL pop_unblocked_rsp: got %b%b %h expected 10 5a5a", rsp0_valid, rsp1_valid, rsp_data);
        end
        next();
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, OP_PUSH_WORD, 16'h7777, 0, OP_POP, '0); next();
        step(0, OP_POP, '0, 1, OP_POP, '0);
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_grant: got %b expected 1", req1_ready);
        end
        next();
        rst = 1'b1;
        drive_idle();
        model_reset();
        #1;
        n_checks++;
        if ({rsp0_valid, rsp1_valid, rsp_data, level, empty} !== {2'b00, 16'h0000, 2'd0, 1'b1}) begin
            n_errors++; $display("FAIL reset_mid: got rsp=%b%b data=%h lvl=%0d empty=%b expected 00 0000 0 1",
                rsp0_valid, rsp1_valid, rsp_data, level, empty);
        end
        do_reset();
    endtask

    task automatic test_overflow_flag();
        do_reset();
        force_wait = 1'b1;
        step(0, OP_POP, '0, 0, OP_POP, '0);
        n_checks++;
        if (err_overflow !== 1'b0) begin
            n_errors++; $display("FAIL err_before_sample: got %b expected 0", err_overflow);
        end
        next();
        force_wait = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, OP_POP, '0, 0, OP_POP, '0);
            n_checks++;
            if (err_overflow !== 1'b1) begin
                n_errors++; $display("FAIL err_sticky %0d: got %b expected 1", i, err_overflow);
            end
            next();
        end
        do_reset();
        step(0, OP_POP, '0, 0, OP_POP, '0);
        n_checks++;
        if (err_overflow !== 1'b0) begin
            n_errors++; $display("FAIL err_cleared: got %b expected 0", err_overflow);
        end
        next();
    endtask

    task automatic test_random();
        logic [11:0] obs, exp;
        logic [1:0]  o0, o1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            o0 = ($urandom_range(0, 1) == 0) ? OP_POP : 2'($urandom_range(1, 3));
            o1 = ($urandom_range(0, 1) == 0) ? OP_POP : 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0, o0, DW'($urandom),
                 $urandom_range(0, 3) != 0, o1, DW'($urandom));
            obs = {req0_ready, req1_ready, sm_en, sm_ctl, rsp0_valid, rsp1_valid,
                   full, empty, err_overflow, level};
            exp = {e_g0, e_g1, e_g0 | e_g1, e_ctl, m_pend == 0, m_pend == 1,
                   m_level == SS, m_level == 0, m_err, LW'(m_level)};
            n_checks++;
            if (obs !== exp) begin
                n_errors++; $display("FAIL rand_ctrl cycle %0d: got %b expected %b", i, obs, exp);
            end
            n_checks++;
            if (sm_data_in !== e_din) begin
                n_errors++; $display("FAIL rand_din cycle %0d: got %h expected %h", i, sm_data_in, e_din);
            end
            n_checks++;
            if (rsp_data !== ((m_pend >= 0) ? m_pend_data : '0)) begin
                n_errors++; $display("FAIL rand_rsp cycle %0d: got %h expected %h", i, rsp_data,
                    (m_pend >= 0) ? m_pend_data : '0);
            end
            next();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_alternate();
        test_split_block();
        test_pop_empty();
        test_reset_mid();
        test_overflow_flag();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
